// File: rtl/bip_control_unit.sv
// Fetch/execute sequencer for the BIP accumulator datapath: one instruction every two cycles until HLT.
// Optional single-step gating of FETCH is enabled by defining BIP_CTRL_STEP_EN (adds port i_Step).
module bip_control_unit #(
  parameter int unsigned NBITS_D    = 16,
  parameter int unsigned NBITS_OP   = 5,
  parameter int unsigned NBITS_ADDR = 11
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_Start,
`ifdef BIP_CTRL_STEP_EN
  input  logic                  i_Step,
`endif
  input  logic [NBITS_D-1:0]    i_Instruction,
  output logic [NBITS_ADDR-1:0] o_PC,
  output logic [NBITS_ADDR-1:0] o_Operand,
  output logic [1:0]            o_SelA,
  output logic                  o_SelB,
  output logic                  o_Op,
  output logic                  o_WrAcc,
  output logic                  o_WrRam,
  output logic                  o_RdRam,
  output logic                  o_Halt,
  output logic                  o_Busy
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT} state_t;

  typedef enum logic [NBITS_OP-1:0] {
    OP_HLT  = NBITS_OP'(0),
    OP_STO  = NBITS_OP'(1),
    OP_LD   = NBITS_OP'(2),
    OP_LDI  = NBITS_OP'(3),
    OP_ADD  = NBITS_OP'(4),
    OP_ADDI = NBITS_OP'(5),
    OP_SUB  = NBITS_OP'(6),
    OP_SUBI = NBITS_OP'(7)
  } opcode_t;

  state_t                  state_q, state_d;
  logic [NBITS_ADDR-1:0]   pc_q, pc_d;
  opcode_t                 opcode;

  assign opcode = opcode_t'(i_Instruction[NBITS_D-1 -: NBITS_OP]);
  assign o_PC   = pc_q;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    o_Operand = '0;
    o_SelA    = 2'b00;
    o_SelB    = 1'b0;
    o_Op      = 1'b0;
    o_WrAcc   = 1'b0;
    o_WrRam   = 1'b0;
    o_RdRam   = 1'b0;
    o_Halt    = 1'b0;
    o_Busy    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_Start) state_d = S_FETCH;
      end
      S_FETCH: begin
        o_Busy = 1'b1;
`ifdef BIP_CTRL_STEP_EN
        if (i_Step) state_d = S_EXEC;
`else
        state_d = S_EXEC;
`endif
      end
      S_EXEC: begin
        o_Busy    = 1'b1;
        o_Operand = i_Instruction[NBITS_ADDR-1:0];
        // HLT parks with PC on the HLT word; every other opcode (including unknown ones) advances.
        if (opcode == OP_HLT) begin
          state_d = S_HALT;
        end else begin
          state_d = S_FETCH;
          pc_d    = pc_q + NBITS_ADDR'(1);
        end
        case (opcode)
          OP_STO:  o_WrRam = 1'b1;
          OP_LD:   begin o_RdRam = 1'b1; o_WrAcc = 1'b1; end
          OP_LDI:  begin o_SelA = 2'b01; o_WrAcc = 1'b1; end
          OP_ADD:  begin o_RdRam = 1'b1; o_SelA = 2'b10; o_WrAcc = 1'b1; end
          OP_ADDI: begin o_SelB = 1'b1; o_SelA = 2'b10; o_WrAcc = 1'b1; end
          OP_SUB:  begin o_RdRam = 1'b1; o_Op = 1'b1; o_SelA = 2'b10; o_WrAcc = 1'b1; end
          OP_SUBI: begin o_SelB = 1'b1; o_Op = 1'b1; o_SelA = 2'b10; o_WrAcc = 1'b1; end
          default: ;
        endcase
      end
      S_HALT: begin
        o_Halt = 1'b1;
        if (i_Start) begin
          pc_d    = '0;
          state_d = S_FETCH;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_bip_control_unit.sv
// Self-checking bench for bip_control_unit: directed programs plus random programs against an
// instruction-level reference model (two cycles per instruction, opcode lookup table).
module tb_bip_control_unit;

  typedef enum int {PH_IDLE, PH_FETCH, PH_EXEC, PH_HALT} phase_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        step = 1'b1;
  logic [15:0] instr;
  logic [10:0] pc_o, operand_o;
  logic [1:0]  sela_o;
  logic        selb_o, op_o, wracc_o, wrram_o, rdram_o, halt_o, busy_o;
  logic [29:0] obs, e;
  logic [15:0] mem [2048];
  int          compares = 0;
  int          fails = 0;
  int          cyc;

  bip_control_unit #(.NBITS_D(16), .NBITS_OP(5), .NBITS_ADDR(11)) dut (
    .i_clk(clk),
    .i_reset(rst),
    .i_Start(start),
`ifdef BIP_CTRL_STEP_EN
    .i_Step(step),
`endif
    .i_Instruction(instr),
    .o_PC(pc_o),
    .o_Operand(operand_o),
    .o_SelA(sela_o),
    .o_SelB(selb_o),
    .o_Op(op_o),
    .o_WrAcc(wracc_o),
    .o_WrRam(wrram_o),
    .o_RdRam(rdram_o),
    .o_Halt(halt_o),
    .o_Busy(busy_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) instr <= mem[pc_o];

  assign obs = {pc_o, operand_o, sela_o, selb_o, op_o, wracc_o, wrram_o, rdram_o, halt_o, busy_o};

  // {SelA[1:0], SelB, Op, WrAcc, WrRam, RdRam} for each opcode as defined by the ISA table.
  function automatic logic [6:0] ctrl_of(input logic [4:0] opc);
    case (opc)
      5'd1:    return 7'b00_0_0_0_1_0;
      5'd2:    return 7'b00_0_0_1_0_1;
      5'd3:    return 7'b01_0_0_1_0_0;
      5'd4:    return 7'b10_0_0_1_0_1;
      5'd5:    return 7'b10_1_0_1_0_0;
      5'd6:    return 7'b10_0_1_1_0_1;
      5'd7:    return 7'b10_1_1_1_0_0;
      default: return 7'b0;
    endcase
  endfunction

  function automatic logic [29:0] expect_out(input phase_t ph, input int pc, input logic [15:0] ins);
    logic [6:0]  c;
    logic [10:0] opnd;
    c    = '0;
    opnd = '0;
    if (ph == PH_EXEC) begin
      c    = ctrl_of(ins[15:11]);
      opnd = ins[10:0];
    end
    return {11'(pc), opnd, c, ph == PH_HALT, (ph == PH_FETCH) || (ph == PH_EXEC)};
  endfunction

  function automatic logic [15:0] mk(input int opc, input int opnd);
    return {5'(opc), 11'(opnd)};
  endfunction

  // Starts from IDLE or HALT and walks the program instruction by instruction until HLT.
  task automatic run_program(input string name, input int max_instr, input bit patch_zero,
                             output int cycles, output int halt_pc);
    int pc;
    int n;
    bit done;
    @(negedge clk); start = 1'b1; step = 1'b1;
    @(negedge clk); start = 1'b0;
    cycles = 0; pc = 0; n = 0; done = 1'b0;
    while (!done && n < max_instr) begin
      e = expect_out(PH_FETCH, pc, 16'h0);
      compares++;
      if (obs !== e) begin
        $display("FAIL %s fetch pc=%0d: got %h expected %h", name, pc, obs, e); fails++;
      end
      start = 1'($urandom_range(0, 1));
      @(negedge clk); cycles++;
      e = expect_out(PH_EXEC, pc, mem[pc]);
      compares++;
      if (obs !== e) begin
        $display("FAIL %s exec pc=%0d: got %h expected %h", name, pc, obs, e); fails++;
      end
      start = 1'($urandom_range(0, 1));
      if (mem[pc][15:11] == 5'd0) done = 1'b1;
      else pc = (pc + 1) % 2048;
      if (patch_zero && n == 0) mem[0] = mk(0, 0);
      n++;
      @(negedge clk); cycles++;
      start = 1'b0;
    end
    compares++;
    if (!done) begin
      $display("FAIL %s timeout: got %0d instructions without HLT expected HLT within %0d", name, n, max_instr);
      fails++;
    end else begin
      e = expect_out(PH_HALT, pc, 16'h0);
      if (obs !== e) begin
        $display("FAIL %s halt: got %h expected %h", name, obs, e); fails++;
      end
    end
    halt_pc = pc;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0;
    #3;
    compares++;
    if (obs !== 30'h0) begin $display("FAIL reset_asserted: got %h expected %h", obs, 30'h0); fails++; end
    @(negedge clk); @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      e = expect_out(PH_IDLE, 0, 16'h0);
      compares++;
      if (obs !== e) begin $display("FAIL idle_hold cycle %0d: got %h expected %h", i, obs, e); fails++; end
    end
  endtask

  task automatic test_prog_ldi_addi_sto();
    int hpc;
    mem[0] = mk(3, 5); mem[1] = mk(5, 3); mem[2] = mk(1, 7); mem[3] = mk(0, 0);
    run_program("ldi_addi_sto", 10, 1'b0, cyc, hpc);
    compares++;
    if (cyc !== 8) begin $display("FAIL halt_latency: got %0d cycles expected 8", cyc); fails++; end
  endtask

  task automatic test_prog_ld_sub();
    int hpc;
    mem[0] = mk(2, 2); mem[1] = mk(6, 4); mem[2] = mk(0, 0);
    run_program("ld_sub", 10, 1'b0, cyc, hpc);
    compares++;
    if (pc_o !== 11'd2) begin $display("FAIL ld_sub_halt_pc: got %0d expected 2", pc_o); fails++; end
  endtask

  task automatic test_nop();
    int hpc;
    mem[0] = mk(31, $urandom_range(0, 2047)); mem[1] = mk(0, 0);
    run_program("nop11111", 4, 1'b0, cyc, hpc);
  endtask

  task automatic test_wrap();
    int hpc;
    for (int i = 0; i < 2048; i++) mem[i] = mk($urandom_range(8, 31), $urandom_range(0, 2047));
    run_program("pc_wrap", 2050, 1'b1, cyc, hpc);
    compares++;
    if (pc_o !== 11'd0) begin $display("FAIL wrap_halt_pc: got %0d expected 0", pc_o); fails++; end
  endtask

  task automatic test_reset_mid_exec();
    int hpc;
    mem[0] = mk(4, 9); mem[1] = mk(0, 0);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    e = expect_out(PH_EXEC, 0, mem[0]);
    compares++;
    if (obs !== e) begin $display("FAIL add_exec_before_reset: got %h expected %h", obs, e); fails++; end
    #1 rst = 1'b1;
    #1;
    compares++;
    if (obs !== 30'h0) begin $display("FAIL reset_mid_exec: got %h expected %h", obs, 30'h0); fails++; end
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    e = expect_out(PH_IDLE, 0, 16'h0);
    compares++;
    if (obs !== e) begin $display("FAIL idle_after_abort: got %h expected %h", obs, e); fails++; end
    mem[0] = mk(3, 1); mem[1] = mk(0, 0);
    run_program("to_halt", 4, 1'b0, cyc, hpc);
    compares++;
    if (hpc != 1 || pc_o !== 11'd1) begin $display("FAIL halt_pc_before_restart: got %0d expected 1", pc_o); fails++; end
    mem[0] = mk(7, 2); mem[1] = mk(0, 0);
    run_program("restart_from_halt", 4, 1'b0, cyc, hpc);
  endtask

  task automatic test_random();
    int len;
    int hpc;
    for (int t = 0; t < 8; t++) begin
      len = $urandom_range(1, 20);
      for (int i = 0; i < len; i++) mem[i] = mk($urandom_range(1, 31), $urandom_range(0, 2047));
      mem[len] = mk(0, $urandom_range(0, 2047));
      run_program("random", len + 2, 1'b0, cyc, hpc);
      compares++;
      if (cyc !== 2 * (len + 1)) begin
        $display("FAIL random_latency len=%0d: got %0d expected %0d", len, cyc, 2 * (len + 1)); fails++;
      end
    end
  endtask

`ifdef BIP_CTRL_STEP_EN
  task automatic test_step();
    mem[0] = mk(3, 1); mem[1] = mk(3, 2); mem[2] = mk(0, 0);
    step = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      e = expect_out(PH_FETCH, 0, 16'h0);
      compares++;
      if (obs !== e) begin $display("FAIL step_hold cycle %0d: got %h expected %h", i, obs, e); fails++; end
      if (i < 4) @(negedge clk);
    end
    step = 1'b1;
    @(negedge clk); step = 1'b0;
    e = expect_out(PH_EXEC, 0, mem[0]);
    compares++;
    if (obs !== e) begin $display("FAIL step_exec: got %h expected %h", obs, e); fails++; end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      e = expect_out(PH_FETCH, 1, 16'h0);
      compares++;
      if (obs !== e) begin $display("FAIL step_one_only cycle %0d: got %h expected %h", i, obs, e); fails++; end
    end
    step = 1'b1;
    @(negedge clk); @(negedge clk); @(negedge clk); @(negedge clk);
    e = expect_out(PH_HALT, 2, 16'h0);
    compares++;
    if (obs !== e) begin $display("FAIL step_held_to_halt: got %h expected %h", obs, e); fails++; end
  endtask
`endif

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 16'h0;
    test_reset();
    test_prog_ldi_addi_sto();
    test_prog_ld_sub();
    test_nop();
    test_wrap();
    test_reset_mid_exec();
    test_random();
`ifdef BIP_CTRL_STEP_EN
    test_step();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no completion expected finish before 2000000");
    $fatal(1, "timeout");
  end

endmodule
